instr_controller: RTL

INSTR_CONTROLLER -- requirements
Module: instr_controller

---
 rtl/instr_controller_pkg.sv | 105 ++++++++++
 rtl/instr_controller_cond_eval.sv | 43 ++++
 rtl/instr_controller.sv | 131 +++++++++++++
 3 files changed

// File: rtl/instr_controller_pkg.sv
// Shared encodings for the multi-cycle instruction controller: FSM states,
// opcode/ext fields, condition codes, PSR flag positions and mux selects.
package instr_controller_pkg;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM_RD = 3'd3,
    S_MEM_WB = 3'd4,
    S_MEM_WR = 3'd5,
    S_BRANCH = 3'd6
  } state_t;

  // Primary opcodes, instr[15:12]
  localparam logic [3:0] OP_RTYPE   = 4'b0000;
  localparam logic [3:0] OP_ANDI    = 4'b0001;
  localparam logic [3:0] OP_ORI     = 4'b0010;
  localparam logic [3:0] OP_XORI    = 4'b0011;
  localparam logic [3:0] OP_SPECIAL = 4'b0100;
  localparam logic [3:0] OP_ADDI    = 4'b0101;
  localparam logic [3:0] OP_SUBI    = 4'b1001;
  localparam logic [3:0] OP_CMPI    = 4'b1011;
  localparam logic [3:0] OP_BCOND   = 4'b1100;
  localparam logic [3:0] OP_MOVI    = 4'b1101;

  // Extended codes under OP_SPECIAL, instr[7:4]
  localparam logic [3:0] EXT_LOAD  = 4'b0000;
  localparam logic [3:0] EXT_STOR  = 4'b0100;
  localparam logic [3:0] EXT_JAL   = 4'b1000;
  localparam logic [3:0] EXT_JCOND = 4'b1100;

  // ALU function codes (ext for R-type, op for immediates)
  localparam logic [3:0] ALU_ADD = 4'b0101;
  localparam logic [3:0] ALU_SUB = 4'b1001;
  localparam logic [3:0] ALU_CMP = 4'b1011;

  // Condition codes, instr[11:8]
  localparam logic [3:0] COND_EQ = 4'd0;
  localparam logic [3:0] COND_NE = 4'd1;
  localparam logic [3:0] COND_CS = 4'd2;
  localparam logic [3:0] COND_CC = 4'd3;
  localparam logic [3:0] COND_LS = 4'd4;
  localparam logic [3:0] COND_LC = 4'd5;
  localparam logic [3:0] COND_NS = 4'd6;
  localparam logic [3:0] COND_NC = 4'd7;
  localparam logic [3:0] COND_FS = 4'd8;
  localparam logic [3:0] COND_FC = 4'd9;
  localparam logic [3:0] COND_GT = 4'd10;
  localparam logic [3:0] COND_LE = 4'd11;
  localparam logic [3:0] COND_HI = 4'd12;
  localparam logic [3:0] COND_LT = 4'd13;
  localparam logic [3:0] COND_UC = 4'd14;
  localparam logic [3:0] COND_NV = 4'd15;

  localparam int unsigned FLAG_C = 0;
  localparam int unsigned FLAG_L = 2;
  localparam int unsigned FLAG_F = 5;
  localparam int unsigned FLAG_Z = 6;
  localparam int unsigned FLAG_N = 7;

  localparam logic [1:0] WB_ALU = 2'b00;
  localparam logic [1:0] WB_MEM = 2'b01;
  localparam logic [1:0] WB_PC1 = 2'b10;

  localparam logic [1:0] PC_INC  = 2'b00;
  localparam logic [1:0] PC_DISP = 2'b01;
  localparam logic [1:0] PC_REG  = 2'b10;

  typedef struct packed {
    logic       instr_en;
    logic       pc_en;
    logic       cmp_f_en;
    logic       of_f_en;
    logic       z_f_en;
    logic       reg_wr_en;
    logic       mem_wr_en;
    logic       addr_sel;
    logic [1:0] wb_sel;
    logic [1:0] pc_src;
  } ctrl_t;

  function automatic logic is_alu_op(input logic [3:0] op);
    return op inside {OP_RTYPE, OP_ANDI, OP_ORI, OP_XORI,
                      OP_ADDI, OP_SUBI, OP_CMPI, OP_MOVI};
  endfunction

  // Final-state class of an instruction; unknown encodings run as NOP in S_EXEC.
  function automatic state_t dispatch_state(input logic [3:0] op, input logic [3:0] ext);
    state_t s;
    s = S_EXEC;
    if (op == OP_BCOND) begin
      s = S_BRANCH;
    end else if (op == OP_SPECIAL) begin
      case (ext)
        EXT_LOAD:           s = S_MEM_RD;
        EXT_STOR:           s = S_MEM_WR;
        EXT_JAL, EXT_JCOND: s = S_BRANCH;
        default:            s = S_EXEC;
      endcase
    end
    return s;
  endfunction

endpackage

// File: rtl/instr_controller_cond_eval.sv
// Branch/jump condition evaluator: condition code plus PSR flags -> taken.
module cond_eval
  import instr_controller_pkg::*;
(
  input  logic [3:0]  cond,
  input  logic [15:0] psr,
  output logic        taken
);

  logic c, l, f, z, n;
  logic unused_psr;

  assign c = psr[FLAG_C];
  assign l = psr[FLAG_L];
  assign f = psr[FLAG_F];
  assign z = psr[FLAG_Z];
  assign n = psr[FLAG_N];
  assign unused_psr = ^{psr[15:8], psr[4:3], psr[1]};

  always_comb begin
    taken = 1'b0;
    case (cond)
      COND_EQ: taken = z;
      COND_NE: taken = !z;
      COND_CS: taken = c;
      COND_CC: taken = !c;
      COND_LS: taken = l;
      COND_LC: taken = !l;
      COND_NS: taken = n;
      COND_NC: taken = !n;
      COND_FS: taken = f;
      COND_FC: taken = !f;
      COND_GT: taken = !l && !z;
      COND_LE: taken = l || z;
      COND_HI: taken = !n && !z;
      COND_LT: taken = n || z;
      COND_UC: taken = 1'b1;
      COND_NV: taken = 1'b0;
      default: taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/instr_controller.sv
// Multi-cycle instruction controller: fetch, two-cycle decode, then one or two
// class-specific states; outputs are registered alongside the state.
module instr_controller
  import instr_controller_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] instr,
  input  logic [15:0] psr,
  output logic        instr_en,
  output logic        pc_en,
  output logic        cmp_f_en,
  output logic        of_f_en,
  output logic        z_f_en,
  output logic        reg_wr_en,
  output logic        mem_wr_en,
  output logic        addr_sel,
  output logic [1:0]  wb_sel,
  output logic [1:0]  pc_src,
  output logic [2:0]  state
);

  state_t     state_q, state_d;
  logic       dec_phase_q, dec_phase_d;
  ctrl_t      ctrl_q, ctrl_d;
  logic       taken;
  logic [3:0] op, ext;
  logic       unused_rsrc;

  assign op          = instr[15:12];
  assign ext         = instr[7:4];
  assign unused_rsrc = ^instr[3:0];

  cond_eval u_cond_eval (
    .cond  (instr[11:8]),
    .psr   (psr),
    .taken (taken)
  );

  function automatic ctrl_t ctrl_for(input state_t s, input logic [3:0] op_f,
                                     input logic [3:0] ext_f, input logic tk);
    ctrl_t      c;
    logic [3:0] code;
    c    = '0;
    code = (op_f == OP_RTYPE) ? ext_f : op_f;
    case (s)
      S_DECODE: c.instr_en = 1'b1;
      S_EXEC: begin
        c.pc_en  = 1'b1;
        c.pc_src = PC_INC;
        if (is_alu_op(op_f)) begin
          c.reg_wr_en = (code != ALU_CMP);
          c.wb_sel    = WB_ALU;
          c.of_f_en   = (code == ALU_ADD) || (code == ALU_SUB);
          c.cmp_f_en  = (code == ALU_CMP);
          c.z_f_en    = (code == ALU_CMP);
        end
      end
      S_MEM_RD: c.addr_sel = 1'b1;
      S_MEM_WB: begin
        c.reg_wr_en = 1'b1;
        c.wb_sel    = WB_MEM;
        c.pc_en     = 1'b1;
        c.pc_src    = PC_INC;
      end
      S_MEM_WR: begin
        c.addr_sel  = 1'b1;
        c.mem_wr_en = 1'b1;
        c.pc_en     = 1'b1;
        c.pc_src    = PC_INC;
      end
      S_BRANCH: begin
        c.pc_en = 1'b1;
        if (op_f == OP_SPECIAL && ext_f == EXT_JAL) begin
          c.pc_src    = PC_REG;
          c.reg_wr_en = 1'b1;
          c.wb_sel    = WB_PC1;
        end else if (op_f == OP_BCOND) begin
          c.pc_src = tk ? PC_DISP : PC_INC;
        end else begin
          c.pc_src = tk ? PC_REG : PC_INC;
        end
      end
      default: c = '0;
    endcase
    return c;
  endfunction

  // Outputs for the upcoming state are computed here and registered with it;
  // instr and psr are stable from the second decode cycle to the final state.
  always_comb begin
    state_d     = state_q;
    dec_phase_d = 1'b0;
    case (state_q)
      S_FETCH:  state_d = S_DECODE;
      S_DECODE: begin
        if (!dec_phase_q) dec_phase_d = 1'b1;
        else              state_d     = dispatch_state(op, ext);
      end
      S_MEM_RD: state_d = S_MEM_WB;
      default:  state_d = S_FETCH;
    endcase
    ctrl_d = ctrl_for(state_d, op, ext, taken);
    if (dec_phase_d) ctrl_d.instr_en = 1'b0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_FETCH;
      dec_phase_q <= 1'b0;
      ctrl_q      <= '0;
    end else begin
      state_q     <= state_d;
      dec_phase_q <= dec_phase_d;
      ctrl_q      <= ctrl_d;
    end
  end

  assign instr_en  = ctrl_q.instr_en;
  assign pc_en     = ctrl_q.pc_en;
  assign cmp_f_en  = ctrl_q.cmp_f_en;
  assign of_f_en   = ctrl_q.of_f_en;
  assign z_f_en    = ctrl_q.z_f_en;
  assign reg_wr_en = ctrl_q.reg_wr_en;
  assign mem_wr_en = ctrl_q.mem_wr_en;
  assign addr_sel  = ctrl_q.addr_sel;
  assign wb_sel    = ctrl_q.wb_sel;
  assign pc_src    = ctrl_q.pc_src;
  assign state     = state_q;

endmodule
